// File: rtl/adder_delay_meter.sv
// rtl/adder_delay_meter.sv - ring-oscillator delay measurement controller for an instrumented adder
// Latches operands, gates the ring, counts synchronised edges over a window and self-checks the sum.
module adder_delay_meter #(
    parameter int WIDTH         = 32,
    parameter int CNT_W         = 32,
    parameter int WIN_W         = 16,
    parameter int SETTLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n,
    input  logic             active,
    input  logic             start,
    input  logic [WIDTH-1:0] cfg_a,
    input  logic [WIDTH-1:0] cfg_b,
    input  logic [WIN_W-1:0] cfg_window,
    output logic [WIDTH-1:0] adder_a,
    output logic [WIDTH-1:0] adder_b,
    input  logic [WIDTH:0]   adder_sum,
    input  logic             ring_osc_in,
    output logic             ring_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    output logic [WIDTH:0]   sum_capture,
    output logic             sum_err
);

    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_MEASURE, ST_DONE} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   w_accept;
    logic                   w_settle_last;
    logic                   w_win_last;
    logic                   w_edge;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sync_q;
    logic [SET_W-1:0]       r_settle_cnt;
    logic [WIN_W-1:0]       r_win;
    logic [WIN_W-1:0]       r_win_cnt;
    logic [WIDTH-1:0]       r_adder_a;
    logic [WIDTH-1:0]       r_adder_b;
    logic [CNT_W-1:0]       r_count;
    logic                   r_overflow;
    logic [WIDTH:0]         r_sum_capture;
    logic                   r_sum_err;

    assign w_settle_last = (r_settle_cnt == '0);
    assign w_win_last    = (r_win_cnt == WIN_W'(1));
    assign w_edge        = r_sync[SYNC_STAGES-1] & ~r_sync_q;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (w_settle_last) begin
                    w_state_nxt = (r_win == '0) ? ST_DONE : ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                if (w_win_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        // Deselecting the project overrides everything, including a same-cycle start.
        if (!active) begin
            w_state_nxt = ST_IDLE;
            w_accept    = 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            r_state       <= ST_IDLE;
            r_sync        <= '0;
            r_sync_q      <= 1'b0;
            r_settle_cnt  <= '0;
            r_win         <= '0;
            r_win_cnt     <= '0;
            r_adder_a     <= '0;
            r_adder_b     <= '0;
            r_count       <= '0;
            r_overflow    <= 1'b0;
            r_sum_capture <= '0;
            r_sum_err     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_sync   <= {r_sync[SYNC_STAGES-2:0], ring_osc_in};
            r_sync_q <= r_sync[SYNC_STAGES-1];

            if (w_accept) begin
                r_adder_a    <= cfg_a;
                r_adder_b    <= cfg_b;
                r_win        <= cfg_window;
                r_count      <= '0;
                r_overflow   <= 1'b0;
                r_sum_err    <= 1'b0;
                r_settle_cnt <= SET_W'(SETTLE_CYCLES - 1);
            end

            if (r_state == ST_SETTLE && active) begin
                if (!w_settle_last) begin
                    r_settle_cnt <= r_settle_cnt - SET_W'(1);
                end else begin
                    r_sum_capture <= adder_sum;
                    r_sum_err     <= (adder_sum != ({1'b0, r_adder_a} + {1'b0, r_adder_b}));
                    r_win_cnt     <= r_win;
                end
            end

            // Saturate rather than wrap; overflow flags an edge lost at all-ones.
            if (r_state == ST_MEASURE && active) begin
                r_win_cnt <= r_win_cnt - WIN_W'(1);
                if (w_edge) begin
                    if (&r_count) begin
                        r_overflow <= 1'b1;
                    end else begin
                        r_count <= r_count + CNT_W'(1);
                    end
                end
            end
        end
    end

    assign ring_en     = (r_state == ST_SETTLE) || (r_state == ST_MEASURE);
    assign busy        = ring_en;
    assign done        = (r_state == ST_DONE);
    assign adder_a     = r_adder_a;
    assign adder_b     = r_adder_b;
    assign count       = r_count;
    assign overflow    = r_overflow;
    assign sum_capture = r_sum_capture;
    assign sum_err     = r_sum_err;

endmodule

// File: tb/tb_adder_delay_meter.sv
// tb/tb_adder_delay_meter.sv - scoreboard bench for adder_delay_meter
module tb_adder_delay_meter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        active;
    logic        start;
    logic [31:0] cfg_a;
    logic [31:0] cfg_b;
    logic [15:0] cfg_window;
    logic        ring;
    logic        force_err;
    logic [32:0] forced_sum;
    logic [32:0] adder_sum;
    logic [31:0] adder_a, adder_b, s_adder_a, s_adder_b;
    logic        ring_en, busy, done, overflow, sum_err;
    logic [31:0] count;
    logic [32:0] sum_capture;
    logic        s_ring_en, s_busy, s_done, s_overflow, s_sum_err;
    logic [3:0]  s_count;
    logic [32:0] s_sum_capture;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int ring_half = 0;

    typedef struct {
        string       name;
        int          start_cyc;
        int          lat;
        int          cnt_lo;
        int          cnt_hi;
        logic [32:0] sum;
        logic        err;
        bit          chk_sat;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    // External adder-under-test model, with an injectable wrong result.
    assign adder_sum = force_err ? forced_sum : ({1'b0, adder_a} + {1'b0, adder_b});

    adder_delay_meter dut (
        .wb_clk_i(clk), .wb_rst_n(rst_n), .active(active), .start(start),
        .cfg_a(cfg_a), .cfg_b(cfg_b), .cfg_window(cfg_window),
        .adder_a(adder_a), .adder_b(adder_b), .adder_sum(adder_sum),
        .ring_osc_in(ring), .ring_en(ring_en), .busy(busy), .done(done),
        .count(count), .overflow(overflow), .sum_capture(sum_capture), .sum_err(sum_err)
    );

    adder_delay_meter #(.CNT_W(4)) dut_sat (
        .wb_clk_i(clk), .wb_rst_n(rst_n), .active(active), .start(start),
        .cfg_a(cfg_a), .cfg_b(cfg_b), .cfg_window(cfg_window),
        .adder_a(s_adder_a), .adder_b(s_adder_b), .adder_sum(adder_sum),
        .ring_osc_in(ring), .ring_en(s_ring_en), .busy(s_busy), .done(s_done),
        .count(s_count), .overflow(s_overflow), .sum_capture(s_sum_capture), .sum_err(s_sum_err)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        int ph = 0;
        ring = 1'b0;
        forever begin
            @(negedge clk);
            if (ring_half == 0) begin
                ring = 1'b0;
                ph = 0;
            end else begin
                ph++;
                if (ph >= ring_half) begin
                    ph = 0;
                    ring = ~ring;
                end
            end
        end
    end

    initial begin
        logic done_q = 1'b0;
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (done && !done_q) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_done: got done=1 at cycle %0d expected no result", cyc);
                end else begin
                    e = sb.pop_front();
                    chk({e.name, ".latency"}, 64'(cyc - e.start_cyc), 64'(e.lat));
                    vectors++;
                    if (int'(count) < e.cnt_lo || int'(count) > e.cnt_hi) begin
                        miscompares++;
                        $display("FAIL %s.count: got %0d expected %0d..%0d", e.name, count, e.cnt_lo, e.cnt_hi);
                    end
                    chk({e.name, ".overflow"}, 64'(overflow), 64'(0));
                    chk({e.name, ".sum_capture"}, 64'(sum_capture), 64'(e.sum));
                    chk({e.name, ".sum_err"}, 64'(sum_err), 64'(e.err));
                    if (e.chk_sat) begin
                        chk({e.name, ".sat_count"}, 64'(s_count), 64'hF);
                        chk({e.name, ".sat_overflow"}, 64'(s_overflow), 64'(1));
                        chk({e.name, ".sat_done"}, 64'(s_done), 64'(1));
                    end
                end
            end
            done_q = done;
        end
    end

    task automatic issue(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input int win, input int half, input int lo, input int hi,
                         input logic [32:0] sum, input logic err, input bit sat);
        exp_t e;
        @(negedge clk);
        ring_half  = half;
        cfg_a      = a;
        cfg_b      = b;
        cfg_window = 16'(win);
        start      = 1'b1;
        e.name = nm; e.start_cyc = cyc; e.lat = 1 + 4 + win;
        e.cnt_lo = lo; e.cnt_hi = hi; e.sum = sum; e.err = err; e.chk_sat = sat;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int bound);
        int n = 0;
        while (!done && n < bound) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL %s.timeout: got done=0 after %0d cycles expected done=1", nm, bound);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, ".ring_en"}, 64'(ring_en), 0);
        chk({nm, ".busy"}, 64'(busy), 0);
        chk({nm, ".done"}, 64'(done), 0);
        chk({nm, ".count"}, 64'(count), 0);
        chk({nm, ".overflow"}, 64'(overflow), 0);
        chk({nm, ".sum_capture"}, 64'(sum_capture), 0);
        chk({nm, ".sum_err"}, 64'(sum_err), 0);
        chk({nm, ".adder_a"}, 64'(adder_a), 0);
        chk({nm, ".adder_b"}, 64'(adder_b), 0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; active = 1'b1; start = 1'b0;
        cfg_a = '0; cfg_b = '0; cfg_window = '0;
        force_err = 1'b0; forced_sum = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ring_en) n++;
        end
        chk("idle.ring_en_cycles", 64'(n), 0);
        check_all_zero("reset");

        issue("basic", 32'h5, 32'h3, 60, 3, 9, 11, 33'h8, 1'b0, 1'b0);
        wait_done("basic", 100);

        issue("carry", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 10, 0, 0, 0, 33'h1_FFFF_FFFE, 1'b0, 1'b0);
        wait_done("carry", 50);

        force_err = 1'b1; forced_sum = 33'h0_FFFF_FFFE;
        issue("sumerr", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 10, 0, 0, 0, 33'h0_FFFF_FFFE, 1'b1, 1'b0);
        wait_done("sumerr", 50);
        force_err = 1'b0;

        issue("sat", 32'h1, 32'h2, 100, 1, 49, 51, 33'h3, 1'b0, 1'b1);
        wait_done("sat", 150);

        // Zero window plus a second start during SETTLE that must be ignored.
        begin
            exp_t e;
            @(negedge clk);
            ring_half = 0; cfg_a = 32'h7; cfg_b = 32'h8; cfg_window = 16'd0; start = 1'b1;
            e.name = "zerowin"; e.start_cyc = cyc; e.lat = 5; e.cnt_lo = 0; e.cnt_hi = 0;
            e.sum = 33'hF; e.err = 1'b0; e.chk_sat = 1'b0;
            sb.push_back(e);
            n = 0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                start = (i == 1);
                cfg_a = (i == 1) ? 32'd99 : 32'h7;
                if (ring_en) n++;
            end
            chk("zerowin.ring_en_cycles", 64'(n), 64'(4));
            chk("zerowin.adder_a_held", 64'(adder_a), 64'h7);
            chk("zerowin.done_held", 64'(done), 64'(1));
        end

        // Abort 20 cycles into MEASURE; no result may be reported.
        @(negedge clk);
        ring_half = 3; cfg_a = 32'd10; cfg_b = 32'd20; cfg_window = 16'd60; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (24) @(negedge clk);
        chk("abort.busy_before", 64'(busy), 64'(1));
        active = 1'b0;
        @(negedge clk);
        chk("abort.ring_en", 64'(ring_en), 0);
        chk("abort.busy", 64'(busy), 0);
        chk("abort.done", 64'(done), 0);
        active = 1'b1;
        repeat (80) @(negedge clk);
        chk("abort.stays_idle", 64'(busy | done), 0);

        @(negedge clk);
        cfg_a = 32'd10; cfg_b = 32'd20; cfg_window = 16'd60; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (24) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_all_zero("midreset");

        issue("after", 32'd100, 32'd23, 30, 2, 6, 9, 33'd123, 1'b0, 1'b0);
        wait_done("after", 60);

        chk("scoreboard_empty", 64'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
